// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM state encodings and
// default widths also used by the pc and ins_mem blocks.
package cpu_ctrl_pkg;

  localparam int PC_W_DEF   = 4;
  localparam int LOOP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_ctrl_up_cnt.sv
// Parameterised up-counter with synchronous clear and enable; clear has
// priority over enable. Used for the instruction and pass counters.
module cpu_ctrl_up_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Run controller for the 4-bit CPU datapath: sequences set_pc / en_ins_mem so
// a program of len_m1+1 instructions runs loops+1 passes from PC 0.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PC_W-1:0]   len_m1,
  input  logic [LOOP_W-1:0] loops,
  output logic              set_pc,
  output logic              en_ins_mem,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]   ins_cnt,
  output logic [LOOP_W-1:0] pass_cnt,
  output logic [1:0]        dbg_state
);

  state_t            state, next_state;
  logic [PC_W-1:0]   len_q;
  logic [LOOP_W-1:0] loops_q;
  logic              accept;
  logic              last_ins, last_pass;
  logic              ins_clr, ins_en, pass_clr, pass_en, done_set;

  // Compare against the current count; the increment that follows the last
  // instruction is never observed in RUN, so no wrap guard is needed.
  assign last_ins  = (ins_cnt == len_q);
  assign last_pass = (pass_cnt == loops_q);
  assign accept    = (state == ST_IDLE) && start && !abort;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      loops_q <= '0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= done_set;
      if (accept) begin
        len_q   <= len_m1;
        loops_q <= loops;
      end
    end
  end

  always_comb begin
    next_state = state;
    ins_clr    = 1'b0;
    ins_en     = 1'b0;
    pass_clr   = 1'b0;
    pass_en    = 1'b0;
    done_set   = 1'b0;
    set_pc     = 1'b1;
    en_ins_mem = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = ST_RUN;
          ins_clr    = 1'b1;
          pass_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        set_pc     = 1'b0;
        en_ins_mem = 1'b1;
        busy       = 1'b1;
        ins_en     = 1'b1;
        if (abort) begin
          next_state = ST_IDLE;
        end else if (last_ins) begin
          if (last_pass) begin
            next_state = ST_IDLE;
            done_set   = 1'b1;
          end else begin
            next_state = ST_RELOAD;
            pass_en    = 1'b1;
          end
        end
      end
      ST_RELOAD: begin
        busy    = 1'b1;
        ins_clr = 1'b1;
        next_state = abort ? ST_IDLE : ST_RUN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  cpu_ctrl_up_cnt #(.W(PC_W)) u_ins_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ins_clr),
    .en    (ins_en),
    .q     (ins_cnt)
  );

  cpu_ctrl_up_cnt #(.W(LOOP_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pass_clr),
    .en    (pass_en),
    .q     (pass_cnt)
  );

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: expected per-cycle traces are built by the
// bench from the run parameters and compared at the falling edge.
module tb_cpu_ctrl;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_RELOAD = 2'd2;

  logic       clk, rst_n, start, abort;
  logic [3:0] len_m1, loops;
  logic       set_pc, en_ins_mem, busy, done;
  logic [3:0] ins_cnt, pass_cnt;
  logic [1:0] dbg_state;
  logic [3:0] pc_model;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  cpu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .len_m1     (len_m1),
    .loops      (loops),
    .set_pc     (set_pc),
    .en_ins_mem (en_ins_mem),
    .busy       (busy),
    .done       (done),
    .ins_cnt    (ins_cnt),
    .pass_cnt   (pass_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PC as the datapath would see it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_model <= 4'd0;
    else        pc_model <= set_pc ? 4'd0 : pc_model + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".state"}, 32'(dbg_state), 32'(S_IDLE));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".set_pc"}, 32'(set_pc), 32'd1);
    chk({tag, ".en"}, 32'(en_ins_mem), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  // Start a run and check every busy cycle against the expected trace
  task automatic run_seq(input string tag, input int len, input int lp, input bit mess);
    logic [9:0] e;
    exp_q.delete();
    for (int p = 0; p <= lp; p++) begin
      for (int i = 0; i <= len; i++) exp_q.push_back({S_RUN, 4'(i), 4'(p)});
      if (p < lp) exp_q.push_back({S_RELOAD, 4'd0, 4'(p + 1)});
    end
    @(negedge clk);
    len_m1 = 4'(len);
    loops  = 4'(lp);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mess) begin
      len_m1 = 4'd15;
      loops  = 4'd15;
      start  = 1'b1;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".state"}, 32'(dbg_state), 32'(e[9:8]));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".set_pc"}, 32'(set_pc), 32'(e[9:8] == S_RELOAD));
      chk({tag, ".en"}, 32'(en_ins_mem), 32'(e[9:8] == S_RUN));
      chk({tag, ".pass"}, 32'(pass_cnt), 32'(e[3:0]));
      chk({tag, ".done"}, 32'(done), 32'd0);
      if (e[9:8] == S_RUN) begin
        chk({tag, ".ins"}, 32'(ins_cnt), 32'(e[7:4]));
        chk({tag, ".ins_pc"}, 32'(ins_cnt), 32'(pc_model));
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk_idle({tag, ".end"}, 1'b1);
    @(negedge clk);
    chk_idle({tag, ".after"}, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len_m1 = 4'd0; loops = 4'd0;
    #2;
    chk_idle("rst0", 1'b0);
    chk("rst0.ins", 32'(ins_cnt), 32'd0);
    chk("rst0.pass", 32'(pass_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle", 1'b0);

    run_seq("single", 3, 0, 1'b0);
    run_seq("loop3", 1, 2, 1'b1);
    run_seq("full", 15, 0, 1'b0);
    run_seq("loop_full", 15, 1, 1'b0);

    // abort in the 3rd RUN cycle of an 8-instruction run
    @(negedge clk);
    len_m1 = 4'd7; loops = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.state", 32'(dbg_state), 32'(S_RUN));
    chk("abort.ins", 32'(ins_cnt), 32'd2);
    chk("abort.en", 32'(en_ins_mem), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    chk_idle("abort.next", 1'b0);
    start = 1'b1;
    @(negedge clk);
    chk_idle("abort.start", 1'b0);
    @(negedge clk);
    chk_idle("abort.hold", 1'b0);
    abort = 1'b0; start = 1'b0;

    // abort during RELOAD
    @(negedge clk);
    len_m1 = 4'd0; loops = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("abrl.run", 32'(dbg_state), 32'(S_RUN));
    @(negedge clk);
    chk("abrl.reload", 32'(dbg_state), 32'(S_RELOAD));
    abort = 1'b1;
    @(negedge clk);
    chk_idle("abrl.next", 1'b0);
    abort = 1'b0;

    // start held high, single-instruction runs back to back
    @(negedge clk);
    len_m1 = 4'd0; loops = 4'd0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b.state", 32'(dbg_state), 32'(S_RUN));
      chk("b2b.ins", 32'(ins_cnt), 32'd0);
      chk("b2b.done0", 32'(done), 32'd0);
      @(negedge clk);
      chk_idle("b2b.idle", 1'b1);
    end
    start = 1'b0;
    @(negedge clk);
    chk_idle("b2b.stop", 1'b0);

    // asynchronous reset mid-run, checked between edges
    @(negedge clk);
    len_m1 = 4'd7; loops = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstrun.ins", 32'(ins_cnt), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk_idle("rstrun", 1'b0);
    chk("rstrun.ins0", 32'(ins_cnt), 32'd0);
    chk("rstrun.pass0", 32'(pass_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rstrun.rel", 1'b0);

    run_seq("post_rst", 2, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Run controller for the 4-bit CPU datapath. It drives the datapath's `set_pc` and `en_ins_mem` inputs so that a program of programmable length executes a programmable number of passes from PC 0, then returns the datapath to a parked state. It sits beside `datapath` under the CPU top level and shares its clock. It is the only block allowed to drive `set_pc` and `en_ins_mem`.

## Interface
- `PC_W`, default 4: program counter / instruction index width; maximum program length is 2^PC_W.
- `LOOP_W`, default 4: pass counter width.

Ports:
- `clk` input 1: single clock, rising edge; same net as `datapath.clk`.
- `rst_n` input 1: reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- `start` input 1: level, sampled in IDLE only; high starts a run.
- `abort` input 1: level; terminates a run early.
- `len_m1` input PC_W: program length minus 1. Captured when `start` is accepted.
- `loops` input LOOP_W: extra passes; total passes = `loops`+1. Captured when `start` is accepted.
- `set_pc` output 1: to datapath; 1 = PC loads 0 at the next edge.
- `en_ins_mem` output 1: to datapath; 0 = instruction memory outputs all-zero, which decodes as a no-write instruction.
- `busy` output 1: high in RUN and RELOAD.
- `done` output 1: one-cycle pulse after the last instruction of the last pass.
- `ins_cnt` output PC_W: index of the instruction executing this cycle; always equals the datapath PC while in RUN.
- `pass_cnt` output LOOP_W: current pass index, starting at 0.

## Operation
- FSM states: IDLE, RUN, RELOAD.
- Outputs by state (combinational, Moore):
  - IDLE: `set_pc`=1, `en_ins_mem`=0, `busy`=0.
  - RUN: `set_pc`=0, `en_ins_mem`=1, `busy`=1.
  - RELOAD: `set_pc`=1, `en_ins_mem`=0, `busy`=1.
- IDLE:
  - `start`=1 and `abort`=0 → RUN.
  - On that transition: capture `len_m1` and `loops`; clear `ins_cnt` and `pass_cnt`.
  - The PC is already 0 on entry to RUN, because IDLE held `set_pc`.
- RUN:
  - `ins_cnt` increments each cycle.
  - When `ins_cnt`==captured `len_m1`:
    - If `pass_cnt`==captured `loops`: go to IDLE and pulse `done`.
    - Otherwise: go to RELOAD and increment `pass_cnt`.
- RELOAD: lasts one cycle; clear `ins_cnt`, then go to RUN.
- `abort`=1 in RUN or RELOAD:
  - Go to IDLE at the next edge; no `done`.
  - The RUN instruction in the abort cycle still completes, since the register write happens at the same edge.
- `abort`=1 together with `start`=1 in IDLE: abort wins, stay in IDLE.
- `start` in RUN or RELOAD: ignored. Changes to `len_m1` or `loops` during a run have no effect.
- Wrap-around: `len_m1`=2^PC_W−1 runs the full memory. The increment after the last instruction is never used.
- `len_m1`=0: RUN lasts one cycle per pass.
- Counters do not wrap inside a run. The compare happens before the increment.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - state IDLE; `set_pc`=1, `en_ins_mem`=0, `busy`=0, `done`=0, `ins_cnt`=0, `pass_cnt`=0.
- Reset mid-run: the outputs above take effect immediately. Register-file contents are undefined and are not restored.
- `start` sampled at edge E: the first RUN cycle follows E, with PC=0 and `ins_cnt`=0.
- Run length: with N=`len_m1`+1 and L=`loops`, `busy` is high for (L+1)·N + L cycles.
- `done` is high in the first IDLE cycle after the final RUN cycle. It is registered: set on the RUN→IDLE transition for normal completion, cleared on the next edge.
- Back-to-back runs: a new `start` is accepted in the same cycle `done` is high.

## Structure
- Shared header `cpu_defs.vh` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_RELOAD`=2'd2;
  - the `PC_W` default, also used by `pc` and `ins_mem`.
- Natural sub-module: `up_cnt`, a parameterised up-counter with synchronous clear and enable, instantiated for `ins_cnt` and `pass_cnt`.
- The FSM and the compare logic live in `cpu_ctrl`.
- The CPU top level instantiates `cpu_ctrl` and `datapath` side by side.

## Test plan
- Reset: hold `rst_n`=0 mid-RUN → outputs go to reset values with no clock edge; after release, state is IDLE and `set_pc`=1.
- `len_m1`=3, `loops`=0, `start` pulse → 4 RUN cycles with `ins_cnt` 0,1,2,3; `done` high on the 5th cycle; `busy` high for 4 cycles.
- `len_m1`=1, `loops`=2 → sequence RUN,RUN,RELOAD,RUN,RUN,RELOAD,RUN,RUN; `pass_cnt` 0→2; `busy` high 8 cycles; single `done`.
- `len_m1`=15, `loops`=0 → 16 RUN cycles with `ins_cnt` 0..15; R0..R3 match the reference model of the 16-instruction program.
- `abort` in the 3rd RUN cycle of a `len_m1`=7 run → that instruction's write is visible; IDLE next cycle; no `done`; `start` with `abort` high in IDLE is ignored.
- `start` held high continuously, `len_m1`=0, `loops`=0 → RUN,IDLE,RUN,IDLE…; `done` on every IDLE cycle.
